// File: rtl/alu_seq.sv
// Handshaked WIDTH-bit ALU: single-cycle logic/arith/shift/compare/MOV,
// iterative shift-add MUL and restoring DIV; result and flags held until accepted.
module alu_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] X,
  output logic [WIDTH-1:0] X_hi,
  output logic [7:0]       Flags
);

  localparam int unsigned SHW = $clog2(WIDTH);

  localparam logic [7:0] OP_ADD  = 8'h01;
  localparam logic [7:0] OP_SUB  = 8'h02;
  localparam logic [7:0] OP_MUL  = 8'h03;
  localparam logic [7:0] OP_DIV  = 8'h04;
  localparam logic [7:0] OP_AND  = 8'h05;
  localparam logic [7:0] OP_OR   = 8'h06;
  localparam logic [7:0] OP_XOR  = 8'h07;
  localparam logic [7:0] OP_NOT  = 8'h08;
  localparam logic [7:0] OP_NAND = 8'h09;
  localparam logic [7:0] OP_NOR  = 8'h0A;
  localparam logic [7:0] OP_XNOR = 8'h0B;
  localparam logic [7:0] OP_SHL  = 8'h0C;
  localparam logic [7:0] OP_SHR  = 8'h0D;
  localparam logic [7:0] OP_CMP  = 8'h0F;
  localparam logic [7:0] OP_MOV  = 8'h80;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d, opd_q, opd_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] x_d, x_hi_d;
  logic [7:0]       flags_d;

  function automatic logic [7:0] pack_flags(input logic z, input logic c, input logic s,
                                            input logic p, input logic o, input logic dz);
    return {dz, o, 1'b0, 1'b0, p, s, c, z};
  endfunction

  // Single-cycle result, evaluated on the live operands at accept
  logic [WIDTH:0]   add_w, sub_w, shl_w, shr_w;
  logic [SHW-1:0]   sh_n;
  logic [WIDTH-1:0] sc_x;
  logic [7:0]       sc_flags;
  logic             sc_c, sc_o, sc_ill, sc_cmp, lt, gt, eq;

  always_comb begin
    sh_n   = B[SHW-1:0];
    add_w  = {1'b0, A} + {1'b0, B};
    sub_w  = {1'b0, A} - {1'b0, B};
    shl_w  = {1'b0, A} << sh_n;
    shr_w  = {A, 1'b0} >> sh_n;
    lt     = (A < B);
    gt     = (A > B);
    eq     = (A == B);
    sc_x   = '0;
    sc_c   = 1'b0;
    sc_o   = 1'b0;
    sc_ill = 1'b0;
    sc_cmp = 1'b0;
    case (op)
      OP_ADD: begin
        sc_x = add_w[WIDTH-1:0];
        sc_c = add_w[WIDTH];
        sc_o = (A[WIDTH-1] == B[WIDTH-1]) && (add_w[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        sc_x = sub_w[WIDTH-1:0];
        sc_c = sub_w[WIDTH];
        sc_o = (A[WIDTH-1] != B[WIDTH-1]) && (sub_w[WIDTH-1] != A[WIDTH-1]);
      end
      OP_MUL, OP_DIV: sc_x = '0;
      OP_AND:  sc_x = A & B;
      OP_OR:   sc_x = A | B;
      OP_XOR:  sc_x = A ^ B;
      OP_NOT:  sc_x = ~A;
      OP_NAND: sc_x = ~(A & B);
      OP_NOR:  sc_x = ~(A | B);
      OP_XNOR: sc_x = ~(A ^ B);
      OP_SHL: begin
        sc_x = shl_w[WIDTH-1:0];
        sc_c = shl_w[WIDTH];
      end
      OP_SHR: begin
        sc_x = shr_w[WIDTH:1];
        sc_c = shr_w[0];
      end
      OP_CMP: begin
        sc_x   = WIDTH'({lt, gt, eq});
        sc_cmp = 1'b1;
      end
      OP_MOV:  sc_x = A;
      default: sc_ill = 1'b1;
    endcase
    if (sc_ill)      sc_flags = 8'h20;
    else if (sc_cmp) sc_flags = {5'b0, lt, gt, eq};
    else             sc_flags = pack_flags(sc_x == '0, sc_c, sc_x[WIDTH-1], ~^sc_x, sc_o, 1'b0);
  end

  // One MUL (shift-add) / DIV (restore) step on the iteration registers
  logic [WIDTH:0]   mul_sum, div_sh, div_diff;
  logic [WIDTH-1:0] mul_hi_n, mul_lo_n, div_hi_n, div_lo_n;
  logic             div_ge, last;

  always_comb begin
    mul_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opd_q} : '0);
    mul_hi_n = mul_sum[WIDTH:1];
    mul_lo_n = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
    div_sh   = {acc_hi_q, acc_lo_q[WIDTH-1]};
    div_ge   = (div_sh >= {1'b0, opd_q});
    div_diff = div_sh - {1'b0, opd_q};
    div_hi_n = div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
    div_lo_n = {acc_lo_q[WIDTH-2:0], div_ge};
    last     = (cnt_q == SHW'(WIDTH - 1));
  end

  // Next-state and result update
  always_comb begin
    state_d  = state_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    opd_d    = opd_q;
    cnt_d    = cnt_q;
    x_d      = X;
    x_hi_d   = X_hi;
    flags_d  = Flags;
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          acc_hi_d = '0;
          cnt_d    = '0;
          if (op == OP_MUL) begin
            state_d  = S_MUL;
            acc_lo_d = B;
            opd_d    = A;
          end else if (op == OP_DIV) begin
            state_d  = S_DIV;
            acc_lo_d = A;
            opd_d    = B;
          end else begin
            state_d = S_DONE;
            x_d     = sc_x;
            x_hi_d  = '0;
            flags_d = sc_flags;
          end
        end
      end
      S_MUL: begin
        acc_hi_d = mul_hi_n;
        acc_lo_d = mul_lo_n;
        cnt_d    = cnt_q + 1'b1;
        if (last) begin
          state_d = S_DONE;
          x_d     = mul_lo_n;
          x_hi_d  = mul_hi_n;
          flags_d = pack_flags({mul_hi_n, mul_lo_n} == '0, mul_hi_n != '0, mul_lo_n[WIDTH-1],
                               ~^mul_lo_n, mul_hi_n != '0, 1'b0);
        end
      end
      S_DIV: begin
        acc_hi_d = div_hi_n;
        acc_lo_d = div_lo_n;
        cnt_d    = cnt_q + 1'b1;
        if (last) begin
          state_d = S_DONE;
          x_d     = div_lo_n;
          x_hi_d  = div_hi_n;
          flags_d = pack_flags(div_lo_n == '0, 1'b0, div_lo_n[WIDTH-1], ~^div_lo_n, 1'b0,
                               opd_q == '0);
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      X         <= '0;
      X_hi      <= '0;
      Flags     <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      opd_q     <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      in_ready  <= (state_d == S_IDLE);
      out_valid <= (state_d == S_DONE);
      X         <= x_d;
      X_hi      <= x_hi_d;
      Flags     <= flags_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      opd_q     <= opd_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule
